// File: rtl/prog_memory_loader.sv
// Instruction store with a streamed valid/ready program-load port and a
// one-cycle fetch port that faults on reads beyond the loaded program.
module prog_memory_loader #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic                  instruction_valid,
  output logic                  fetch_fault,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   wptr_reg, wptr_next;
  logic [ADDR_WIDTH:0]     load_count_reg, load_count_next;
  logic                    load_done_reg, load_done_next;
  logic                    mem_we;
  logic                    transfer;
  logic                    last_word;
  logic                    fetch_in_range;

  logic [DATA_WIDTH-1:0]   instr_reg;
  logic                    instr_valid_reg;
  logic                    fetch_fault_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // load_start outranks a coincident transfer, so that word is dropped.
  assign transfer  = (state_reg == LOAD) && load_valid && !load_start;
  assign last_word = load_last || (&wptr_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wptr_reg       <= '0;
      load_count_reg <= '0;
      load_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wptr_reg       <= wptr_next;
      load_count_reg <= load_count_next;
      load_done_reg  <= load_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wptr_next       = wptr_reg;
    load_count_next = load_count_reg;
    load_done_next  = 1'b0;
    mem_we          = 1'b0;
    if (load_start) begin
      state_next = LOAD;
      wptr_next  = '0;
    end else if (transfer) begin
      mem_we    = 1'b0 | 1'b1;
      wptr_next = wptr_reg + 1'b1;
      if (last_word) begin
        // Count is one wider than the pointer so a full memory reads as DEPTH.
        state_next      = RUN;
        load_count_next = {1'b0, wptr_reg} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        load_done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_reg] <= load_data;
    end
  end

  assign fetch_in_range = ({1'b0, fetch_addr} < load_count_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_reg       <= NOP_WORD;
      instr_valid_reg <= 1'b0;
      fetch_fault_reg <= 1'b0;
    end else if (fetch_en) begin
      if ((state_reg == RUN) && fetch_in_range) begin
        instr_reg       <= mem[fetch_addr];
        instr_valid_reg <= 1'b1;
        fetch_fault_reg <= 1'b0;
      end else begin
        instr_reg       <= NOP_WORD;
        instr_valid_reg <= 1'b0;
        fetch_fault_reg <= 1'b1;
      end
    end else begin
      instr_valid_reg <= 1'b0;
      fetch_fault_reg <= 1'b0;
    end
  end

  assign load_ready        = (state_reg == LOAD);
  assign busy              = (state_reg == LOAD);
  assign load_done         = load_done_reg;
  assign load_count        = load_count_reg;
  assign instruction_out   = instr_reg;
  assign instruction_valid = instr_valid_reg;
  assign fetch_fault       = fetch_fault_reg;

endmodule

// File: tb/tb_prog_memory_loader.sv
// Scoreboard bench: the driver feeds a behavioural model that queues expected
// fetch results and load completions; a monitor pops them as the DUT answers.
module tb_prog_memory_loader;

  localparam int             DW    = 16;
  localparam int             AW    = 8;
  localparam int             DEPTH = 256;
  localparam logic [DW-1:0]  NOP   = 16'h0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          load_done;
  logic [AW:0]   load_count;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] instruction_out;
  logic          instruction_valid;
  logic          fetch_fault;
  logic          busy;

  prog_memory_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instruction_out(instruction_out), .instruction_valid(instruction_valid),
    .fetch_fault(fetch_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: 0 = idle, 1 = loading, 2 = running.
  int            m_mode = 0;
  int            m_wptr = 0;
  int            m_count = 0;
  logic [DW-1:0] m_mem [int];
  logic          exp_busy = 1'b0;

  logic [DW+1:0] fq[$];   // {word, valid, fault}
  logic [AW:0]   dq[$];   // expected load_count on each load_done

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cycle(input logic ls, input logic lv, input logic ll,
                       input logic [DW-1:0] ld, input logic fe, input int fa);
    @(negedge clk);
    load_start = ls; load_valid = lv; load_last = ll; load_data = ld;
    fetch_en = fe; fetch_addr = AW'(fa);
    if (fe) begin
      if (m_mode == 2 && fa < m_count) fq.push_back({m_mem[fa], 2'b10});
      else                             fq.push_back({NOP, 2'b01});
    end
    if (ls) begin
      m_mode = 1;
      m_wptr = 0;
    end else if (m_mode == 1 && lv) begin
      m_mem[m_wptr] = ld;
      if (ll || m_wptr == DEPTH - 1) begin
        m_count = m_wptr + 1;
        m_mode  = 2;
        dq.push_back((AW+1)'(m_count));
      end
      m_wptr++;
    end
    exp_busy = (m_mode == 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0);
  endtask

  task automatic fetch(input int a);
    cycle(0, 0, 0, '0, 1, a);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_count", load_count, 0);
    chk("rst_valid", instruction_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_instr", instruction_out, NOP);
    fq.delete(); dq.delete();
    m_mode = 0; m_wptr = 0; m_count = 0; exp_busy = 1'b0;
    load_start = 0; load_valid = 0; load_last = 0; fetch_en = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("busy", busy, exp_busy);
      chk("load_ready", load_ready, exp_busy);
      if (instruction_valid || fetch_fault) begin
        if (fq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_fetch: got valid=%b fault=%b expected none", instruction_valid, fetch_fault);
        end else begin
          chk("fetch", {instruction_out, instruction_valid, fetch_fault}, fq.pop_front());
        end
      end
      if (load_done) begin
        if (dq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got load_done=1 expected 0");
        end else begin
          chk("load_count", load_count, dq.pop_front());
        end
      end
    end
  end

  initial begin
    int fa;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Fetch before any load faults.
    fetch(0);
    idle(1);

    // Three-word load with last on the third.
    cycle(1, 0, 0, '0, 0, 0);
    cycle(0, 1, 0, 16'h1111, 0, 0);
    cycle(0, 1, 0, 16'h2222, 0, 0);
    cycle(0, 1, 1, 16'h3333, 0, 0);
    fetch(0); fetch(1); fetch(2); fetch(3);
    idle(1);

    // Toggling valid, four words.
    cycle(1, 0, 0, '0, 0, 0);
    cycle(0, 1, 0, 16'hA001, 0, 0);
    cycle(0, 0, 0, 16'hDEAD, 0, 0);
    cycle(0, 1, 0, 16'hA002, 0, 0);
    cycle(0, 0, 0, 16'hDEAD, 0, 0);
    cycle(0, 1, 0, 16'hA003, 0, 0);
    cycle(0, 0, 0, 16'hDEAD, 0, 0);
    cycle(0, 1, 1, 16'hA004, 1, 0);
    for (int i = 0; i < 5; i++) fetch(i);

    // Fill the whole memory without last; the extra word must be dropped.
    cycle(1, 0, 0, '0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) cycle(0, 1, 0, DW'(16'h5000 + i), 0, 0);
    fetch(0); fetch(1); fetch(254); fetch(255);

    // Restart discards the coincident word.
    cycle(1, 0, 0, '0, 0, 0);
    cycle(0, 1, 0, 16'h1234, 0, 0);
    cycle(1, 1, 0, 16'hBEEF, 0, 0);
    cycle(0, 1, 1, 16'hAAAA, 0, 0);
    fetch(0); fetch(1);

    // Asynchronous reset mid-load, then a fetch must fault.
    cycle(1, 0, 0, '0, 0, 0);
    cycle(0, 1, 0, 16'h7777, 0, 0);
    async_reset();
    fetch(0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      fa = ($urandom % 2) ? $urandom_range(0, m_count + 2) : ($urandom % DEPTH);
      if (fa > DEPTH - 1) fa = DEPTH - 1;
      cycle(($urandom % 40) == 0, $urandom % 2, ($urandom % 8) == 0,
            DW'($urandom), $urandom % 2, fa);
    end
    idle(3);

    n_cmp++;
    if (fq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d fetch / %0d done pending expected 0", fq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
